// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the 9-bit processor program sequencer.
// Holds the FSM state enum, opcode field layout and retire-counter width.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_STEP_WAIT,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int         OPC_HI      = 8;
    localparam int         OPC_LO      = 6;
    localparam int         ICOUNT_W    = 16;

    // Retired-instruction counter increment that sticks at all-ones.
    function automatic logic [ICOUNT_W-1:0] sat_inc(
        input logic [ICOUNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// EXEC-phase watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th consecutive cycle is reached.
module seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Count EXEC cycles without completion; restart on every new EXEC entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches ROM words, runs them on the processor, retires.
// Optional EXEC watchdog enabled by defining PROC_SEQ_WATCHDOG_EN.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 9,
    parameter int PROG_LEN = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Step_mode,
    input  logic                Step,
    input  logic                Loop,
    input  logic                Halt_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W-1:0]   Instr,
    output logic                Run,
    input  logic                Done,
    output logic                Busy,
    output logic                Halted,
    output logic                Fault,
    output logic [ADDR_W-1:0]   PC,
    output logic [ICOUNT_W-1:0] Icount
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [DATA_W-1:0]   instr_q;
    logic                run_q;
    logic [ICOUNT_W-1:0] icount_q;
    logic [ICOUNT_W-1:0] icount_d;
    logic                at_end;
    logic                end_halt;
    logic                is_halt;
    logic                wd_expired;

    // Next PC and retire count for the instruction completing in EXEC.
    always_comb begin
        at_end   = (pc_q == LAST_PC);
        end_halt = at_end && !Loop;
        is_halt  = (rom_data[OPC_HI:OPC_LO] == HALT_OPCODE);
        icount_d = sat_inc(icount_q);
        pc_d     = pc_q + 1'b1;
        if (at_end) begin
            pc_d = Loop ? '0 : pc_q;
        end
    end

`ifdef PROC_SEQ_WATCHDOG_EN
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .clear_i   (state_q == S_LOAD),
        .enable_i  (state_q == S_EXEC),
        .expired_o (wd_expired)
    );

    assign Fault = (state_q == S_FAULT);
`else
    // Without the watchdog EXEC waits for Done forever.
    assign wd_expired = (TIMEOUT < 0);
    assign Fault      = 1'b0;
`endif

    // Sequencer FSM with registered PC, Instr, Run and retire count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            run_q    <= 1'b0;
            icount_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (Start) begin
                        pc_q     <= '0;
                        icount_q <= '0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    instr_q <= rom_data;
                    if (is_halt || Halt_req) begin
                        state_q <= S_HALTED;
                    end else begin
                        run_q   <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (Done) begin
                        run_q    <= 1'b0;
                        icount_q <= icount_d;
                        pc_q     <= pc_d;
                        if (end_halt || Halt_req) begin
                            state_q <= S_HALTED;
                        end else if (Step_mode) begin
                            state_q <= S_STEP_WAIT;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else if (wd_expired) begin
                        run_q   <= 1'b0;
                        state_q <= S_FAULT;
                    end
                end
                S_STEP_WAIT: begin
                    if (Halt_req) begin
                        state_q <= S_HALTED;
                    end else if (Step || !Step_mode) begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    run_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = pc_q;
    assign PC       = pc_q;
    assign Instr    = instr_q;
    assign Run      = run_q;
    assign Icount   = icount_q;
    assign Busy     = (state_q == S_FETCH) ||
                      (state_q == S_LOAD)  ||
                      (state_q == S_EXEC);
    assign Halted   = (state_q == S_HALTED);

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: directed programs, ROM and processor
// models; a negedge monitor checks every Run window and every halt.
module tb_proc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Step_mode;
    logic        Step;
    logic        Loop;
    logic        Halt_req;
    logic [4:0]  rom_addr;
    logic [8:0]  rom_data = '0;
    logic [8:0]  Instr;
    logic        Run;
    logic        Done;
    logic        Busy;
    logic        Halted;
    logic        Fault;
    logic [4:0]  PC;
    logic [15:0] Icount;

    logic        mdl_done = 1'b0;
    logic        tb_done;
    int          lat;
    int          mdl_cnt = 0;

    logic [8:0]  rom [0:31];

    typedef struct {
        bit          is_halt;
        logic [8:0]  instr;
        logic [4:0]  pc;
        logic [15:0] icnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int run_rises = 0;
    bit run_prev = 1'b0;
    bit halt_prev = 1'b0;

    assign Done = mdl_done | tb_done;

    proc_sequencer #(
        .ADDR_W   (5),
        .DATA_W   (9),
        .PROG_LEN (4),
        .TIMEOUT  (8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Step_mode (Step_mode),
        .Step      (Step),
        .Loop      (Loop),
        .Halt_req  (Halt_req),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .Instr     (Instr),
        .Run       (Run),
        .Done      (Done),
        .Busy      (Busy),
        .Halted    (Halted),
        .Fault     (Fault),
        .PC        (PC),
        .Icount    (Icount)
    );

    always #5 Clock = ~Clock;

    // Synchronous program ROM.
    always @(posedge Clock) rom_data <= rom[rom_addr];

    // Processor model: Done in the lat-th Run cycle, never if lat is 0.
    always @(negedge Clock) begin
        if (Reset || !Run) begin
            mdl_cnt  = 0;
            mdl_done = 1'b0;
        end else begin
            mdl_cnt  = mdl_cnt + 1;
            mdl_done = (lat != 0) && (mdl_cnt == lat);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per Run window start and per halt.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (Run && !run_prev) begin
                run_rises++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_run: unexpected Run pc=%0d got 1 expected 0", PC);
                end else begin
                    mon_e = sb.pop_front();
                    chk("run_kind", 32'(mon_e.is_halt), 0);
                    chk("run_instr", 32'(Instr), 32'(mon_e.instr));
                    chk("run_pc", 32'(PC), 32'(mon_e.pc));
                end
            end
            if (Halted && !halt_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_halt: unexpected halt pc=%0d got 1 expected 0", PC);
                end else begin
                    mon_e = sb.pop_front();
                    chk("halt_kind", 32'(mon_e.is_halt), 1);
                    chk("halt_pc", 32'(PC), 32'(mon_e.pc));
                    chk("halt_icount", 32'(Icount), 32'(mon_e.icnt));
                end
            end
        end
        run_prev  = Run;
        halt_prev = Halted;
    end

    task automatic push_run(input logic [8:0] i, input logic [4:0] p);
        exp_t e;
        e.is_halt = 1'b0;
        e.instr   = i;
        e.pc      = p;
        e.icnt    = '0;
        sb.push_back(e);
    endtask

    task automatic push_halt(input logic [4:0] p, input logic [15:0] c);
        exp_t e;
        e.is_halt = 1'b1;
        e.instr   = '0;
        e.pc      = p;
        e.icnt    = c;
        sb.push_back(e);
    endtask

    task automatic load_rom(input logic [8:0] w0, input logic [8:0] w1,
                            input logic [8:0] w2, input logic [8:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic start_pulse();
        @(posedge Clock);
        #1 Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (run_rises < target && n < budget) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk("run_window_seen", 32'(run_rises >= target), 1);
    endtask

    task automatic wait_halted(input int budget);
        int n = 0;
        while (!Halted && n < budget) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk("halted_reached", 32'(Halted), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((Run || Busy) && n < budget) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk("window_closed", 32'(Run || Busy), 0);
    endtask

    task automatic sb_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic do_step(output int cyc);
        @(posedge Clock);
        #1 Step = 1'b1;
        @(posedge Clock);
        #1 Step = 1'b0;
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (!Run && cyc < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        int cyc;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        Reset     = 1'b1;
        Start     = 1'b0;
        Step_mode = 1'b0;
        Step      = 1'b0;
        Loop      = 1'b0;
        Halt_req  = 1'b0;
        tb_done   = 1'b0;
        lat       = 4;

        // Reset state
        repeat (3) @(negedge Clock);
        chk("rst_run", 32'(Run), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_fault", 32'(Fault), 0);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_icount", 32'(Icount), 0);
        chk("rst_instr", 32'(Instr), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        Reset = 1'b0;

        // Basic run: mvi, add, sub, halt; a Start mid-EXEC is ignored
        load_rom(9'o100, 9'o201, 9'o301, 9'o700);
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_run(9'o301, 2);
        push_halt(3, 3);
        base = run_rises;
        start_pulse();
        wait_rises(base + 1, 40);
        start_pulse();
        wait_halted(200);
        sb_drain();

        // Done while halted must not retire anything
        @(posedge Clock);
        #1 tb_done = 1'b1;
        @(posedge Clock);
        #1 tb_done = 1'b0;
        repeat (2) @(negedge Clock);
        chk("stray_done_icount", 32'(Icount), 3);
        chk("stray_done_halted", 32'(Halted), 1);

        // End of program without HALT word, Loop=0
        load_rom(9'o100, 9'o201, 9'o301, 9'o101);
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_run(9'o301, 2);
        push_run(9'o101, 3);
        push_halt(3, 4);
        start_pulse();
        wait_halted(200);
        sb_drain();

        // Loop=1 wraps; Halt_req in the 6th window stops after its Done
        Loop = 1'b1;
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_run(9'o301, 2);
        push_run(9'o101, 3);
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_halt(2, 6);
        base = run_rises;
        start_pulse();
        wait_rises(base + 6, 200);
        Halt_req = 1'b1;
        @(negedge Clock);
        chk("halt_req_run_held", 32'(Run), 1);
        chk("halt_req_not_halted", 32'(Halted), 0);
        wait_halted(50);
        Halt_req = 1'b0;
        Loop = 1'b0;
        sb_drain();

        // Step mode: one window per Step, release by clearing Step_mode
        load_rom(9'o100, 9'o201, 9'o301, 9'o700);
        Step_mode = 1'b1;
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_run(9'o301, 2);
        push_halt(3, 3);
        base = run_rises;
        start_pulse();
        wait_rises(base + 1, 40);
        wait_idle(40);
        repeat (6) @(negedge Clock);
        chk("step_parked_rises", 32'(run_rises), 32'(base + 1));
        chk("step_parked_halted", 32'(Halted), 0);
        do_step(cyc);
        chk("step1_latency", 32'(cyc), 3);
        wait_idle(40);
        repeat (6) @(negedge Clock);
        chk("step1_one_window", 32'(run_rises), 32'(base + 2));
        do_step(cyc);
        chk("step2_latency", 32'(cyc), 3);
        wait_idle(40);
        chk("step2_one_window", 32'(run_rises), 32'(base + 3));
        Step_mode = 1'b0;
        wait_halted(40);
        sb_drain();

        // Reset during the second EXEC window
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        base = run_rises;
        start_pulse();
        wait_rises(base + 2, 60);
        chk("pre_reset_pc", 32'(PC), 1);
        Reset = 1'b1;
        #1;
        chk("arst_run", 32'(Run), 0);
        chk("arst_pc", 32'(PC), 0);
        chk("arst_icount", 32'(Icount), 0);
        chk("arst_busy", 32'(Busy), 0);
        chk("arst_instr", 32'(Instr), 0);
        @(negedge Clock);
        Reset = 1'b0;
        sb_drain();

`ifdef PROC_SEQ_WATCHDOG_EN
        // Withheld Done: fault after TIMEOUT EXEC cycles, Start recovers
        lat = 0;
        push_run(9'o100, 0);
        base = run_rises;
        start_pulse();
        wait_rises(base + 1, 40);
        cyc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (!Run) break;
            cyc++;
        end
        chk("wd_exec_cycles", 32'(cyc), 8);
        chk("wd_fault", 32'(Fault), 1);
        chk("wd_busy", 32'(Busy), 0);
        lat = 4;
        push_run(9'o100, 0);
        push_run(9'o201, 1);
        push_run(9'o301, 2);
        push_halt(3, 3);
        start_pulse();
        chk("wd_fault_cleared", 32'(Fault), 0);
        wait_halted(200);
        sb_drain();
`else
        // No watchdog: withheld Done keeps Run high with no fault
        lat = 0;
        push_run(9'o100, 0);
        base = run_rises;
        start_pulse();
        wait_rises(base + 1, 40);
        repeat (100) @(negedge Clock);
        chk("nowd_run_held", 32'(Run), 1);
        chk("nowd_fault", 32'(Fault), 0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        lat = 4;
        sb_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Program sequencer for the 9-bit simple processor. It fetches instruction words from a synchronous program ROM, presents each word to the processor's bus input, and holds `Run` high until the processor pulses `Done`. It then advances the program counter and repeats until it reaches a HALT opcode, the end of the program, or an external halt request. It also supports single-step operation for board debug.

## Interface
Parameters:
- `ADDR_W`, 5, ROM address width.
- `DATA_W`, 9, instruction width.
- `PROG_LEN`, 32, number of valid program words (≤ 2^ADDR_W).
- `TIMEOUT`, 64, watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- `Clock`  in  1  single clock; everything is rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle pulse that begins execution at PC=0.
- `Step_mode`  in  1  when 1, the sequencer stops after each instruction.
- `Step`  in  1  one-cycle pulse that releases the next instruction in step mode.
- `Loop`  in  1  when 1, the PC wraps to 0 after `PROG_LEN`-1 instead of halting.
- `Halt_req`  in  1  level; requests a stop at the next instruction boundary.
- `rom_addr`  out  ADDR_W  ROM address; ROM data is valid one cycle later.
- `rom_data`  in  DATA_W  registered ROM output.
- `Instr`  out  DATA_W  instruction driven to the processor.
- `Run`  out  1  processor run enable.
- `Done`  in  1  processor completion pulse, one cycle.
- `Busy`  out  1  high in FETCH, LOAD and EXEC.
- `Halted`  out  1  high in HALTED.
- `Fault`  out  1  watchdog fault.
- `PC`  out  ADDR_W  current program counter.
- `Icount`  out  16  number of retired instructions.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, STEP_WAIT, HALTED, FAULT.
- **Reset:** state=IDLE. PC, `rom_addr`, `Instr` and `Icount` are 0. `Run`, `Busy`, `Halted` and `Fault` are 0.
- **IDLE / HALTED / FAULT + Start:** clear PC and `Icount`, clear `Fault`, go to FETCH. `Start` in any other state is ignored.
- **FETCH:** `rom_addr`=PC; go to LOAD.
- **LOAD:** capture `rom_data` into `Instr`.
  - If `Instr[8:6]`=3'b111 (HALT opcode): go to HALTED without asserting `Run`; `Icount` unchanged.
  - Else if `Halt_req`=1: go to HALTED.
  - Otherwise go to EXEC.
- **EXEC:** `Run`=1, `Instr` stable. On `Done`=1:
  - `Run` drops in the next cycle.
  - `Icount`++, saturating at 16'hFFFF.
  - PC advances as follows:
    - PC=`PROG_LEN`-1 and `Loop`=1: PC becomes 0.
    - PC=`PROG_LEN`-1 and `Loop`=0: go to HALTED; PC holds at `PROG_LEN`-1.
    - Otherwise PC++.
  - Next state, in priority order:
    1. `Halt_req` → HALTED.
    2. `Step_mode` → STEP_WAIT.
    3. Otherwise → FETCH.
- **STEP_WAIT:**
  - `Step` → FETCH.
  - `Halt_req` → HALTED; this takes priority over `Step`.
  - Clearing `Step_mode` while in STEP_WAIT also proceeds to FETCH.
- `Done` outside EXEC is ignored.
- `Halt_req` arriving during EXEC never truncates the instruction; `Run` stays high until `Done`.
- Reset mid-EXEC drops `Run` asynchronously, and all registers return to their reset values.

## Timing
- `Start` at edge n → FETCH in cycle n+1 → LOAD in n+2 → `Run`=1 from cycle n+3.
- `Done` sampled at edge m → `Run`=0 in cycle m+1 → FETCH in m+1 → `Run`=1 again in m+3. Overhead between instructions is 2 cycles.
- `Instr` changes only on the LOAD edge and never while `Run`=1.
- `Busy`, `Halted` and `Fault` are decoded from registered state; there is no combinational path from inputs to outputs.

## Configuration
- `PROC_SEQ_WATCHDOG_EN` defined:
  - A cycle counter clears on entry to EXEC.
  - If `Done` is absent for `TIMEOUT` consecutive EXEC cycles, `Run` drops and the state becomes FAULT with `Fault`=1.
  - `Fault` is cleared only by `Start` or `Reset`.
- Undefined: no counter and no FAULT transition; `Fault` is tied to 0 and EXEC waits indefinitely.

## Structure
- Package `proc_seq_pkg` holds:
  - the state enum;
  - `HALT_OPCODE`=3'b111;
  - opcode field position [8:6];
  - the `Icount` width.
- One sub-module, `seq_watchdog`: a TIMEOUT counter with `clear`/`enable` inputs and an `expired` output. It is instantiated only under `PROC_SEQ_WATCHDOG_EN`.

## Test plan
- **Basic run:** ROM = {mvi, add, sub, 9'o700}; `Start`; processor model returns `Done` 4 cycles after `Run`.
  - Expect 3 `Run` windows with `Instr` equal to each word.
  - Expect `Halted`=1, `Icount`=3, PC=3.
- **End of program:** `PROG_LEN`=4, no HALT word, `Loop`=0 → halts with PC=3 and `Icount`=4. With `Loop`=1 → PC sequence 0,1,2,3,0,1…
- **Step mode:** `Step_mode`=1 → the sequencer sits in STEP_WAIT after each `Done`. Each `Step` pulse produces exactly one `Run` window, starting 3 cycles after `Step`.
- **Halt request:** `Halt_req` asserted mid-EXEC → `Run` holds until `Done`, then `Halted`=1. `Icount` includes that instruction.
- **Watchdog** (macro on, `TIMEOUT`=8): `Done` withheld → `Run` drops after 8 EXEC cycles and `Fault`=1. A later `Start` clears `Fault` and restarts at PC=0.
- **Reset during EXEC:** `Reset` pulse with `Run`=1 → `Run`=0 immediately, PC=0, `Icount`=0, state IDLE.
